hazard_ctrl_mc: RTL and testbench
=================================

// Module: hazard_ctrl_mc
// PURPOSE
//  Pipeline hazard controller for the 5-stage RV32 core (F_D, D_E, E_M, M_W regs), second generation.
//  Adds x0 filtering, rs-used qualification, multi-cycle data-memory wait, iterative MUL/DIV busy stall,
//  an optional no-forwarding mode and a stall-cycle performance counter to load-use and branch handling.
//  Drives stall/flush of PC and all pipeline registers; sits beside the datapath.
// PARAMETERS
//  IDX_W      5   register index width
//  DM_LAT     2   data-memory load latency in cycles (1 = single-cycle, no wait state)
//  MDU_LAT    4   MUL/DIV execute latency in cycles (>=2)
//  FWD_EN     1   1: E_M->E forwarding exists; 0: also stall on RAW against E_M rd
//  CNT_W      32  width of stall performance counter
// PORTS
//  clk              in   1      rising-edge clock
//  rst_n            in   1      asynchronous, active-low reset
//  F_D_rs1_index    in   IDX_W  decode-stage rs1
//  F_D_rs2_index    in   IDX_W  decode-stage rs2
//  F_D_rs1_used     in   1      decode instruction reads rs1
//  F_D_rs2_used     in   1      decode instruction reads rs2
//  D_E_rd_index     in   IDX_W  execute-stage rd
//  D_E_mem_read     in   1      execute-stage instruction is a load
//  D_E_reg_write    in   1      execute-stage instruction writes rd
//  D_E_mdu_op       in   1      execute-stage instruction is MUL/DIV
//  E_M_rd_index     in   IDX_W  memory-stage rd
//  E_M_reg_write    in   1      memory-stage instruction writes rd
//  E_M_mem_read     in   1      memory-stage instruction is a load
//  E_M_branch_taken in   1      taken branch/jump resolved in E_M
//  PC_stall, F_D_stall, D_E_stall, E_M_stall  out 1  hold register
//  F_D_flush, D_E_flush, E_M_flush, M_W_flush out 1  load bubble into register
//  mdu_start        out  1      one-cycle start pulse to MUL/DIV unit
//  stall_cycles     out  CNT_W  count of cycles with PC_stall=1, wraps
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, counter=0, stall_cycles=0; all stall/flush outputs and mdu_start 0.
//  - RAW match (rsX): rsX_used && rsX!=0 && rsX==rd. x0 never causes a hazard.
//  - load_use = D_E_mem_read && D_E_reg_write && RAW(D_E_rd); nofwd = !FWD_EN && E_M_reg_write && RAW(E_M_rd).
//  - FSM states IDLE, MEM_WAIT, MDU_BUSY; cnt sized clog2(max(DM_LAT,MDU_LAT)+1).
//  - IDLE, priority high->low:
//    1 E_M_branch_taken: F_D/D_E/E_M_flush=1, no stalls, stay IDLE (kills any MDU op in D_E: no mdu_start).
//    2 E_M_mem_read && DM_LAT>1: go MEM_WAIT, cnt=DM_LAT-1; this cycle PC,F_D,D_E,E_M stall, M_W_flush=1.
//    3 D_E_mdu_op: mdu_start=1, go MDU_BUSY, cnt=MDU_LAT-1; PC,F_D,D_E stall, E_M_flush=1.
//    4 load_use|nofwd: PC_stall, F_D_stall, D_E_flush=1 (one bubble per cycle while condition holds).
//  - MEM_WAIT: PC,F_D,D_E,E_M stall, M_W_flush=1; cnt decrements; at cnt==1 return IDLE (total stall DM_LAT-1 cycles).
//  - MDU_BUSY: PC,F_D,D_E stall, E_M_flush=1; cnt decrements; at cnt==1 return IDLE, D_E advances next cycle.
//    Branch cannot be resolved in E_M during MDU_BUSY (E_M holds bubbles); E_M_branch_taken ignored there.
//  - Stall and flush of the same register never both asserted; flush wins only in the branch case (no stall then).
//  - Outputs combinational from state and inputs; only state, cnt, stall_cycles are registered.
//  - stall_cycles += 1 on every clock with PC_stall=1; wraps at 2^CNT_W to 0.
//  - Reset asserted mid-MEM_WAIT/MDU_BUSY: immediate return to IDLE, cnt=0, outputs 0.
// STRUCTURE
//  - Shared package (core_pkg): hz_state_e {IDLE,MEM_WAIT,MDU_BUSY}, REG_IDX_W, X0 constant.
//  - One sub-module: hazard_raw_cmp (combinational rs1/rs2 vs rd compare with used/x0 filtering),
//    instantiated twice (D_E rd, E_M rd). FSM, counter and perf counter in top.
// TESTING
//  - Load-use: D_E load rd=5, F_D rs1=5 used -> PC_stall=F_D_stall=D_E_flush=1 one cycle, then clear.
//  - x0/unused: D_E load rd=0, rs1=0; and rd=7 with rs2=7 but rs2_used=0 -> no stall.
//  - Mem wait DM_LAT=3: E_M_mem_read=1 -> PC/F_D/D_E/E_M stall, M_W_flush for exactly 2 cycles.
//  - MDU MDU_LAT=4: D_E_mdu_op=1 -> mdu_start pulse 1 cycle, stalls 4 cycles, E_M_flush each cycle.
//  - Branch+MDU same cycle: E_M_branch_taken=1, D_E_mdu_op=1 -> 3 flushes, mdu_start=0, stay IDLE.
//  - FWD_EN=0: E_M rd=3 writes, F_D rs1=3 -> stall; rst_n low during MDU_BUSY -> all outputs 0 at once.

Source files
------------

// File: rtl/hazard_ctrl_mc_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_mc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        MDU_BUSY = 2'd2
    } hz_state_e;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] X0 = '0;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_ctrl_mc_raw_cmp.sv
// Read-after-write compare of both decode operands against one producer rd.
// An operand only matches when the instruction actually reads it and it is not x0.
module hazard_ctrl_mc_raw_cmp
    import hazard_ctrl_mc_pkg::*;
#(
    parameter int IDX_W = REG_IDX_W
) (
    input  logic [IDX_W-1:0] rs1_index,
    input  logic [IDX_W-1:0] rs2_index,
    input  logic             rs1_used,
    input  logic             rs2_used,
    input  logic [IDX_W-1:0] rd_index,
    output logic             raw_hit
);

    logic rs1_hit;
    logic rs2_hit;

    // per-operand match with x0 and unused-operand filtering
    always_comb begin
        rs1_hit = rs1_used && (rs1_index != IDX_W'(X0)) && (rs1_index == rd_index);
        rs2_hit = rs2_used && (rs2_index != IDX_W'(X0)) && (rs2_index == rd_index);
        raw_hit = rs1_hit || rs2_hit;
    end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the 5-stage RV32 pipeline: load-use, no-forwarding RAW,
// multi-cycle data-memory wait, iterative MUL/DIV stall, branch flush and a
// stall-cycle performance counter.
//
// state    | meaning
// ---------+-------------------------------------------------------------------
// IDLE     | normal issue; branch, mem-wait entry, MDU start, RAW bubbles
// MEM_WAIT | load in E_M still waiting on data memory; front of pipe frozen
// MDU_BUSY | MUL/DIV iterating; D_E held, bubbles fed into E_M
//
// MEM_WAIT stalls while cnt > 1; the cnt == 1 cycle releases the pipe so the
// load leaves E_M (otherwise IDLE would see the same load again), giving
// DM_LAT-1 stall cycles in total. MDU_BUSY stalls through cnt == 1 and hands
// back to IDLE with cnt = 1 as a one-cycle marker, so the finished MUL/DIV
// still sitting in D_E advances instead of being restarted.
module hazard_ctrl_mc
    import hazard_ctrl_mc_pkg::*;
#(
    parameter int IDX_W   = REG_IDX_W,
    parameter int DM_LAT  = 2,
    parameter int MDU_LAT = 4,
    parameter int FWD_EN  = 1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] F_D_rs1_index,
    input  logic [IDX_W-1:0] F_D_rs2_index,
    input  logic             F_D_rs1_used,
    input  logic             F_D_rs2_used,
    input  logic [IDX_W-1:0] D_E_rd_index,
    input  logic             D_E_mem_read,
    input  logic             D_E_reg_write,
    input  logic             D_E_mdu_op,
    input  logic [IDX_W-1:0] E_M_rd_index,
    input  logic             E_M_reg_write,
    input  logic             E_M_mem_read,
    input  logic             E_M_branch_taken,
    output logic             PC_stall,
    output logic             F_D_stall,
    output logic             D_E_stall,
    output logic             E_M_stall,
    output logic             F_D_flush,
    output logic             D_E_flush,
    output logic             E_M_flush,
    output logic             M_W_flush,
    output logic             mdu_start,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int CW          = $clog2(max2(DM_LAT, MDU_LAT) + 1);
    localparam bit MEM_WAIT_EN = (DM_LAT > 1);
    localparam bit NOFWD_MODE  = (FWD_EN == 0);

    hz_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic raw_de;
    logic raw_em;
    logic load_use;
    logic nofwd;

    logic eval_issue;
    logic allow_br_mem;
    logic allow_mdu;

    logic pc_stall_c, f_d_stall_c, d_e_stall_c, e_m_stall_c;
    logic f_d_flush_c, d_e_flush_c, e_m_flush_c, m_w_flush_c;
    logic mdu_start_c;

    hazard_ctrl_mc_raw_cmp #(.IDX_W(IDX_W)) u_raw_de (
        .rs1_index (F_D_rs1_index),
        .rs2_index (F_D_rs2_index),
        .rs1_used  (F_D_rs1_used),
        .rs2_used  (F_D_rs2_used),
        .rd_index  (D_E_rd_index),
        .raw_hit   (raw_de)
    );

    hazard_ctrl_mc_raw_cmp #(.IDX_W(IDX_W)) u_raw_em (
        .rs1_index (F_D_rs1_index),
        .rs2_index (F_D_rs2_index),
        .rs1_used  (F_D_rs1_used),
        .rs2_used  (F_D_rs2_used),
        .rd_index  (E_M_rd_index),
        .raw_hit   (raw_em)
    );

    // hazard conditions that cost a single decode bubble
    always_comb begin
        load_use = D_E_mem_read && D_E_reg_write && raw_de;
        nofwd    = NOFWD_MODE && E_M_reg_write && raw_em;
    end

    // next state, wait counter and raw stall/flush decisions
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        eval_issue   = 1'b0;
        allow_br_mem = 1'b0;
        allow_mdu    = 1'b0;
        pc_stall_c   = 1'b0;
        f_d_stall_c  = 1'b0;
        d_e_stall_c  = 1'b0;
        e_m_stall_c  = 1'b0;
        f_d_flush_c  = 1'b0;
        d_e_flush_c  = 1'b0;
        e_m_flush_c  = 1'b0;
        m_w_flush_c  = 1'b0;
        mdu_start_c  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d        = '0;
                eval_issue   = 1'b1;
                allow_br_mem = 1'b1;
                allow_mdu    = (cnt_q == '0);
            end
            MEM_WAIT: begin
                if (cnt_q > CW'(1)) begin
                    pc_stall_c  = 1'b1;
                    f_d_stall_c = 1'b1;
                    d_e_stall_c = 1'b1;
                    e_m_stall_c = 1'b1;
                    m_w_flush_c = 1'b1;
                    cnt_d       = cnt_q - CW'(1);
                end else begin
                    // release cycle: the load drains, younger stages may still need handling
                    state_d    = IDLE;
                    cnt_d      = '0;
                    eval_issue = 1'b1;
                    allow_mdu  = 1'b1;
                end
            end
            MDU_BUSY: begin
                pc_stall_c  = 1'b1;
                f_d_stall_c = 1'b1;
                d_e_stall_c = 1'b1;
                e_m_flush_c = 1'b1;
                cnt_d       = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = IDLE;
                    cnt_d   = CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (eval_issue) begin
            if (allow_br_mem && E_M_branch_taken) begin
                f_d_flush_c = 1'b1;
                d_e_flush_c = 1'b1;
                e_m_flush_c = 1'b1;
            end else if (allow_br_mem && MEM_WAIT_EN && E_M_mem_read) begin
                state_d     = MEM_WAIT;
                cnt_d       = CW'(DM_LAT - 1);
                pc_stall_c  = 1'b1;
                f_d_stall_c = 1'b1;
                d_e_stall_c = 1'b1;
                e_m_stall_c = 1'b1;
                m_w_flush_c = 1'b1;
            end else if (allow_mdu && D_E_mdu_op) begin
                state_d     = MDU_BUSY;
                cnt_d       = CW'(MDU_LAT - 1);
                mdu_start_c = 1'b1;
                pc_stall_c  = 1'b1;
                f_d_stall_c = 1'b1;
                d_e_stall_c = 1'b1;
                e_m_flush_c = 1'b1;
            end else if (load_use || nofwd) begin
                pc_stall_c  = 1'b1;
                f_d_stall_c = 1'b1;
                d_e_flush_c = 1'b1;
            end
        end
    end

    // performance counter: one tick per frozen-PC cycle, wraps naturally
    always_comb begin
        stall_cycles_d = stall_cycles_q + CNT_W'(pc_stall_c);
    end

    // state, wait counter and perf counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // outputs held quiet while reset is asserted, whatever the inputs show
    always_comb begin
        PC_stall     = rst_n && pc_stall_c;
        F_D_stall    = rst_n && f_d_stall_c;
        D_E_stall    = rst_n && d_e_stall_c;
        E_M_stall    = rst_n && e_m_stall_c;
        F_D_flush    = rst_n && f_d_flush_c;
        D_E_flush    = rst_n && d_e_flush_c;
        E_M_flush    = rst_n && e_m_flush_c;
        M_W_flush    = rst_n && m_w_flush_c;
        mdu_start    = rst_n && mdu_start_c;
        stall_cycles = stall_cycles_q;
    end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench: instance a forwards (FWD_EN=1, 32-bit counter), instance b
// does not (FWD_EN=0, 4-bit counter so the wrap is reachable). Both use
// DM_LAT=3, MDU_LAT=4. Output vectors are {PC,F_D,D_E,E_M stall, F_D,D_E,E_M,M_W flush, mdu_start}.
module tb_hazard_ctrl_mc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] F_D_rs1_index, F_D_rs2_index, D_E_rd_index, E_M_rd_index;
    logic       F_D_rs1_used, F_D_rs2_used;
    logic       D_E_mem_read, D_E_reg_write, D_E_mdu_op;
    logic       E_M_reg_write, E_M_mem_read, E_M_branch_taken;

    logic        a_pc_s, a_fd_s, a_de_s, a_em_s, a_fd_f, a_de_f, a_em_f, a_mw_f, a_start;
    logic        b_pc_s, b_fd_s, b_de_s, b_em_s, b_fd_f, b_de_f, b_em_f, b_mw_f, b_start;
    logic [31:0] a_cnt;
    logic [3:0]  b_cnt;
    logic [8:0]  out_a, out_b;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [8:0] NONE = 9'b000000000;
    localparam logic [8:0] LU   = 9'b110001000;
    localparam logic [8:0] MEM  = 9'b111100010;
    localparam logic [8:0] MDUS = 9'b111000101;
    localparam logic [8:0] MDUB = 9'b111000100;
    localparam logic [8:0] BR   = 9'b000011100;

    assign out_a = {a_pc_s, a_fd_s, a_de_s, a_em_s, a_fd_f, a_de_f, a_em_f, a_mw_f, a_start};
    assign out_b = {b_pc_s, b_fd_s, b_de_s, b_em_s, b_fd_f, b_de_f, b_em_f, b_mw_f, b_start};

    always #5 clk = ~clk;

    hazard_ctrl_mc #(.IDX_W(5), .DM_LAT(3), .MDU_LAT(4), .FWD_EN(1), .CNT_W(32)) u_a (
        .clk(clk), .rst_n(rst_n),
        .F_D_rs1_index(F_D_rs1_index), .F_D_rs2_index(F_D_rs2_index),
        .F_D_rs1_used(F_D_rs1_used), .F_D_rs2_used(F_D_rs2_used),
        .D_E_rd_index(D_E_rd_index), .D_E_mem_read(D_E_mem_read),
        .D_E_reg_write(D_E_reg_write), .D_E_mdu_op(D_E_mdu_op),
        .E_M_rd_index(E_M_rd_index), .E_M_reg_write(E_M_reg_write),
        .E_M_mem_read(E_M_mem_read), .E_M_branch_taken(E_M_branch_taken),
        .PC_stall(a_pc_s), .F_D_stall(a_fd_s), .D_E_stall(a_de_s), .E_M_stall(a_em_s),
        .F_D_flush(a_fd_f), .D_E_flush(a_de_f), .E_M_flush(a_em_f), .M_W_flush(a_mw_f),
        .mdu_start(a_start), .stall_cycles(a_cnt)
    );

    hazard_ctrl_mc #(.IDX_W(5), .DM_LAT(3), .MDU_LAT(4), .FWD_EN(0), .CNT_W(4)) u_b (
        .clk(clk), .rst_n(rst_n),
        .F_D_rs1_index(F_D_rs1_index), .F_D_rs2_index(F_D_rs2_index),
        .F_D_rs1_used(F_D_rs1_used), .F_D_rs2_used(F_D_rs2_used),
        .D_E_rd_index(D_E_rd_index), .D_E_mem_read(D_E_mem_read),
        .D_E_reg_write(D_E_reg_write), .D_E_mdu_op(D_E_mdu_op),
        .E_M_rd_index(E_M_rd_index), .E_M_reg_write(E_M_reg_write),
        .E_M_mem_read(E_M_mem_read), .E_M_branch_taken(E_M_branch_taken),
        .PC_stall(b_pc_s), .F_D_stall(b_fd_s), .D_E_stall(b_de_s), .E_M_stall(b_em_s),
        .F_D_flush(b_fd_f), .D_E_flush(b_de_f), .E_M_flush(b_em_f), .M_W_flush(b_mw_f),
        .mdu_start(b_start), .stall_cycles(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        F_D_rs1_index = '0; F_D_rs2_index = '0; F_D_rs1_used = 1'b0; F_D_rs2_used = 1'b0;
        D_E_rd_index = '0; D_E_mem_read = 1'b0; D_E_reg_write = 1'b0; D_E_mdu_op = 1'b0;
        E_M_rd_index = '0; E_M_reg_write = 1'b0; E_M_mem_read = 1'b0; E_M_branch_taken = 1'b0;
    endtask

    // inputs were set at a falling edge: check both instances, then move to the next falling edge
    task automatic apply(input string tag, input logic [8:0] ea, input logic [8:0] eb);
        #1;
        chk({tag, "_a"}, {23'd0, out_a}, {23'd0, ea});
        chk({tag, "_b"}, {23'd0, out_b}, {23'd0, eb});
        @(negedge clk);
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        D_E_rd_index = 5'd5; D_E_mem_read = 1'b1; D_E_reg_write = 1'b1;
        F_D_rs1_index = 5'd5; F_D_rs1_used = 1'b1;
        #2;
        chk("rst_outs_a", {23'd0, out_a}, 32'd0);
        chk("rst_outs_b", {23'd0, out_b}, 32'd0);
        chk("rst_cnt_a", a_cnt, 32'd0);
        chk("rst_cnt_b", {28'd0, b_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clr();
        apply("idle", NONE, NONE);

        // load-use on rs1, then the bubble clears it
        D_E_rd_index = 5'd5; D_E_mem_read = 1'b1; D_E_reg_write = 1'b1;
        F_D_rs1_index = 5'd5; F_D_rs1_used = 1'b1;
        apply("lu_rs1", LU, LU);
        clr();
        apply("lu_clear", NONE, NONE);
        chk("cnt_lu_a", a_cnt, 32'd1);

        // x0 and unused-operand filtering, then a real rs2 hit
        D_E_rd_index = 5'd0; D_E_mem_read = 1'b1; D_E_reg_write = 1'b1;
        F_D_rs1_index = 5'd0; F_D_rs1_used = 1'b1;
        apply("x0", NONE, NONE);
        D_E_rd_index = 5'd7; F_D_rs1_index = 5'd3; F_D_rs2_index = 5'd7; F_D_rs2_used = 1'b0;
        apply("rs2_unused", NONE, NONE);
        F_D_rs2_used = 1'b1;
        apply("lu_rs2", LU, LU);
        clr();

        // data-memory wait: exactly two stall cycles, then the load drains
        E_M_mem_read = 1'b1;
        apply("mem_c1", MEM, MEM);
        apply("mem_c2", MEM, MEM);
        apply("mem_rel", NONE, NONE);
        clr();
        apply("mem_done", NONE, NONE);
        chk("cnt_mem_a", a_cnt, 32'd4);

        // MUL/DIV: one start pulse, four stall cycles, no restart of the finished op
        D_E_mdu_op = 1'b1;
        apply("mdu_c1", MDUS, MDUS);
        apply("mdu_c2", MDUB, MDUB);
        apply("mdu_c3", MDUB, MDUB);
        apply("mdu_c4", MDUB, MDUB);
        apply("mdu_rel", NONE, NONE);
        clr();
        apply("mdu_done", NONE, NONE);
        chk("cnt_mdu_a", a_cnt, 32'd8);
        chk("cnt_mdu_b", {28'd0, b_cnt}, 32'd8);

        // branch beats MDU and mem-wait; controller stays in IDLE
        E_M_branch_taken = 1'b1; D_E_mdu_op = 1'b1;
        apply("br_mdu", BR, BR);
        clr();
        apply("br_after", NONE, NONE);
        E_M_branch_taken = 1'b1; E_M_mem_read = 1'b1;
        D_E_rd_index = 5'd5; D_E_mem_read = 1'b1; D_E_reg_write = 1'b1;
        F_D_rs1_index = 5'd5; F_D_rs1_used = 1'b1;
        apply("br_mem", BR, BR);
        clr();
        apply("br_mem_after", NONE, NONE);
        chk("cnt_br_a", a_cnt, 32'd8);

        // no-forwarding RAW against E_M only stalls instance b
        E_M_rd_index = 5'd3; E_M_reg_write = 1'b1;
        F_D_rs1_index = 5'd3; F_D_rs1_used = 1'b1;
        apply("nofwd", NONE, LU);
        chk("cnt_nofwd_b", {28'd0, b_cnt}, 32'd9);
        E_M_rd_index = 5'd0; F_D_rs1_index = 5'd0;
        apply("nofwd_x0", NONE, NONE);
        E_M_rd_index = 5'd3; F_D_rs1_index = 5'd3;
        for (int i = 0; i < 7; i++) apply("nofwd_run", NONE, LU);
        chk("cnt_wrap_b", {28'd0, b_cnt}, 32'd0);
        chk("cnt_wrap_a", a_cnt, 32'd8);
        clr();

        // reset while MDU_BUSY
        D_E_mdu_op = 1'b1;
        apply("mdu_r1", MDUS, MDUS);
        apply("mdu_r2", MDUB, MDUB);
        chk("cnt_pre_rst_a", a_cnt, 32'd10);
        rst_n = 1'b0;
        #1;
        chk("rst_busy_a", {23'd0, out_a}, 32'd0);
        chk("rst_busy_b", {23'd0, out_b}, 32'd0);
        chk("rst_busy_cnt_a", a_cnt, 32'd0);
        chk("rst_busy_cnt_b", {28'd0, b_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply("post_rst_mdu", MDUS, MDUS);
        clr();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
